alu_ct_mdu: RTL and testbench

//  Next-generation ALU control for the MIPS core. Decodes alu_ct_op/funct into an ALU_CT_W-bit ALU code
//  (full R-type logic/arith set) and runs an iterative multiply/divide unit (MDU) that owns the HI/LO registers.

---
 rtl/alu_ct_pkg.sv | 48 ++++
 rtl/mdu_iter.sv | 152 +++++++++++++++
 rtl/alu_ct_mdu.sv | 84 ++++++++
 tb/tb_alu_ct_mdu.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ct_pkg.sv
// Shared constants for the MIPS ALU-control / multiply-divide block:
// ALU codes, alu_ct_op encodings, R-type functs and the MDU state encoding.
package alu_ct_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_SUB   = 2'b01;
   localparam logic [1:0] OP_RTYPE = 2'b10;
   localparam logic [1:0] OP_OR    = 2'b11;

   localparam logic [1:0] SEL_ALU = 2'b00;
   localparam logic [1:0] SEL_HI  = 2'b01;
   localparam logic [1:0] SEL_LO  = 2'b10;

   localparam logic [5:0] F_ADD   = 6'b100000;
   localparam logic [5:0] F_ADDU  = 6'b100001;
   localparam logic [5:0] F_SUB   = 6'b100010;
   localparam logic [5:0] F_SUBU  = 6'b100011;
   localparam logic [5:0] F_AND   = 6'b100100;
   localparam logic [5:0] F_OR    = 6'b100101;
   localparam logic [5:0] F_NOR   = 6'b100111;
   localparam logic [5:0] F_SLT   = 6'b101010;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   typedef enum logic [1:0] {
      MDU_IDLE = 2'b00,
      MDU_MUL  = 2'b01,
      MDU_DIV  = 2'b10,
      MDU_FIX  = 2'b11
   } mdu_state_e;

   // mult/multu/div/divu share the 0110xx pattern
   function automatic logic is_mdu_funct(input logic [5:0] f);
      return f[5:2] == 4'b0110;
   endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: one bit per cycle on magnitudes, then a
// single sign-fix cycle that commits HI/LO and raises done.
//
// state    | meaning
// MDU_IDLE | waiting for start; HI/LO hold last result
// MDU_MUL  | shift-add, one multiplier bit per cycle
// MDU_DIV  | restoring division, one quotient bit per cycle
// MDU_FIX  | apply result signs, write HI/LO
module mdu_iter
   import alu_ct_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              is_div,
   input  logic              is_signed,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo,
   output logic              busy,
   output logic              done
);

   localparam int CNT_W = $clog2(DATA_W);

   mdu_state_e state, state_nxt;

   logic [CNT_W-1:0]    cnt;
   logic                cnt_tc;
   logic [DATA_W-1:0]   mcand;
   logic [DATA_W-1:0]   acc_hi;
   logic [DATA_W-1:0]   acc_lo;
   logic                neg_q;
   logic                neg_r;
   logic                b_zero;
   logic                div_op;
   logic [DATA_W-1:0]   hi_q;
   logic [DATA_W-1:0]   lo_q;
   logic                done_q;

   logic                a_neg;
   logic                b_neg;
   logic [DATA_W-1:0]   a_mag;
   logic [DATA_W-1:0]   b_mag;
   logic [DATA_W:0]     mul_sum;
   logic [DATA_W:0]     div_shift;
   logic [DATA_W:0]     div_trial;
   logic [2*DATA_W-1:0] prod;
   logic [2*DATA_W-1:0] prod_fix;
   logic [DATA_W-1:0]   quo_fix;
   logic [DATA_W-1:0]   rem_fix;

   assign cnt_tc = (cnt == '0);

   always_ff @(posedge clk) begin
      if (!rst) state <= MDU_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         MDU_IDLE: if (start) state_nxt = is_div ? MDU_DIV : MDU_MUL;
         MDU_MUL,
         MDU_DIV:  if (cnt_tc) state_nxt = MDU_FIX;
         MDU_FIX:  state_nxt = MDU_IDLE;
         default:  state_nxt = MDU_IDLE;
      endcase
   end

   assign a_neg = is_signed & a[DATA_W-1];
   assign b_neg = is_signed & b[DATA_W-1];
   assign a_mag = a_neg ? -a : a;
   assign b_mag = b_neg ? -b : b;

   assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
   assign div_shift = {acc_hi, acc_lo[DATA_W-1]};
   assign div_trial = div_shift - {1'b0, mcand};

   // magnitude INT_MIN / 1 already yields INT_MIN after negation, so no special case
   assign prod     = {acc_hi, acc_lo};
   assign prod_fix = neg_q ? -prod : prod;
   assign quo_fix  = neg_q ? -acc_lo : acc_lo;
   assign rem_fix  = neg_r ? -acc_hi : acc_hi;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt    <= '0;
         mcand  <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         b_zero <= 1'b0;
         div_op <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            MDU_IDLE: begin
               if (start) begin
                  mcand  <= b_mag;
                  acc_lo <= a_mag;
                  acc_hi <= '0;
                  cnt    <= CNT_W'(DATA_W - 1);
                  neg_q  <= a_neg ^ b_neg;
                  neg_r  <= a_neg;
                  b_zero <= (b == '0);
                  div_op <= is_div;
               end
            end
            MDU_MUL: begin
               acc_hi <= mul_sum[DATA_W:1];
               acc_lo <= {mul_sum[0], acc_lo[DATA_W-1:1]};
               cnt    <= cnt - 1'b1;
            end
            MDU_DIV: begin
               if (!div_trial[DATA_W]) begin
                  acc_hi <= div_trial[DATA_W-1:0];
                  acc_lo <= {acc_lo[DATA_W-2:0], 1'b1};
               end else begin
                  acc_hi <= div_shift[DATA_W-1:0];
                  acc_lo <= {acc_lo[DATA_W-2:0], 1'b0};
               end
               cnt <= cnt - 1'b1;
            end
            MDU_FIX: begin
               done_q <= 1'b1;
               if (div_op) begin
                  // divide by zero: remainder already holds A, quotient is all ones
                  hi_q <= rem_fix;
                  lo_q <= b_zero ? '1 : quo_fix;
               end else begin
                  {hi_q, lo_q} <= prod_fix;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != MDU_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: rtl/alu_ct_mdu.sv
// MIPS ALU control: decodes alu_ct_op/funct into the ALU code and HI/LO
// writeback select, launches the iterative MDU and stalls the pipeline while it runs.
module alu_ct_mdu
   import alu_ct_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ALU_CT_W = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                op_valid,
   input  logic [1:0]          alu_ct_op,
   input  logic [5:0]          funct,
   input  logic [DATA_W-1:0]   src_a,
   input  logic [DATA_W-1:0]   src_b,
   output logic [ALU_CT_W-1:0] alu_ct,
   output logic [1:0]          hilo_sel,
   output logic [DATA_W-1:0]   hi,
   output logic [DATA_W-1:0]   lo,
   output logic                busy,
   output logic                done,
   output logic                stall
);

   logic [3:0] alu_code;
   logic [1:0] sel_code;
   logic       mdu_op;
   logic       mf_op;
   logic       start;

   always_comb begin
      alu_code = ALU_AND;
      sel_code = SEL_ALU;
      mf_op    = 1'b0;
      case (alu_ct_op)
         OP_ADD: alu_code = ALU_ADD;
         OP_SUB: alu_code = ALU_SUB;
         OP_OR:  alu_code = ALU_OR;
         default: begin
            case (funct)
               F_ADD, F_ADDU: alu_code = ALU_ADD;
               F_SUB, F_SUBU: alu_code = ALU_SUB;
               F_AND:         alu_code = ALU_AND;
               F_OR:          alu_code = ALU_OR;
               F_NOR:         alu_code = ALU_NOR;
               F_SLT:         alu_code = ALU_SLT;
               F_MFHI: begin
                  sel_code = SEL_HI;
                  mf_op    = 1'b1;
               end
               F_MFLO: begin
                  sel_code = SEL_LO;
                  mf_op    = 1'b1;
               end
               default:       alu_code = ALU_AND;
            endcase
         end
      endcase
   end

   assign mdu_op = (alu_ct_op == OP_RTYPE) && is_mdu_funct(funct);

   // busy is exactly "MDU not idle", so it also gates acceptance of a new start
   assign start = op_valid & mdu_op & ~busy;

   mdu_iter #(.DATA_W(DATA_W)) u_mdu (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .is_div    (funct[1]),
      .is_signed (~funct[0]),
      .a         (src_a),
      .b         (src_b),
      .hi        (hi),
      .lo        (lo),
      .busy      (busy),
      .done      (done)
   );

   assign alu_ct   = rst ? ALU_CT_W'(alu_code) : '0;
   assign hilo_sel = rst ? sel_code : 2'b00;
   assign stall    = rst & (busy | (op_valid & mdu_op & busy) | (op_valid & mf_op & busy));

endmodule

// File: tb/tb_alu_ct_mdu.sv
// Self-checking bench for alu_ct_mdu: directed decode/timing/reset scenarios
// plus random MDU operations against an arithmetic reference model.
module tb_alu_ct_mdu;

   logic        clk = 1'b0;
   logic        rst;
   logic        op_valid;
   logic [1:0]  alu_ct_op;
   logic [5:0]  funct;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic [3:0]  alu_ct;
   logic [1:0]  hilo_sel;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        done;
   logic        stall;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [1:0] op;
      logic [5:0] f;
      logic [3:0] code;
      logic [1:0] sel;
      logic       valid;
   } dec_row_t;

   dec_row_t rows[$];

   always #5 clk = ~clk;

   alu_ct_mdu #(.DATA_W(32), .ALU_CT_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .op_valid  (op_valid),
      .alu_ct_op (alu_ct_op),
      .funct     (funct),
      .src_a     (src_a),
      .src_b     (src_b),
      .alu_ct    (alu_ct),
      .hilo_sel  (hilo_sel),
      .hi        (hi),
      .lo        (lo),
      .busy      (busy),
      .done      (done),
      .stall     (stall)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add_row(input logic [1:0] op, input logic [5:0] f, input logic [3:0] code,
                          input logic [1:0] sel, input logic valid);
      dec_row_t r;
      r.op = op; r.f = f; r.code = code; r.sel = sel; r.valid = valid;
      rows.push_back(r);
   endtask

   // Reference: plain MIPS semantics on 64-bit / int arithmetic
   task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] eh, output logic [31:0] el);
      longint           ps;
      longint unsigned  pu;
      int               sa, sb;
      sa = a;
      sb = b;
      eh = 0; el = 0;
      case (f)
         6'b011000: begin ps = longint'(sa) * longint'(sb); {eh, el} = ps; end
         6'b011001: begin pu = {32'h0, a} * {32'h0, b}; {eh, el} = pu; end
         6'b011010: begin
            if (b == 0) begin eh = a; el = 32'hFFFF_FFFF; end
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin eh = 0; el = a; end
            else begin el = sa / sb; eh = sa % sb; end
         end
         default: begin
            if (b == 0) begin eh = a; el = 32'hFFFF_FFFF; end
            else begin el = a / b; eh = a % b; end
         end
      endcase
   endtask

   // Called at a drive point with the MDU idle; start is "cycle 0"
   task automatic run_mdu(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] eh, el, hi0, lo0;
      int done_at, busy_n, busy_first, busy_last;
      bit early;
      model(f, a, b, eh, el);
      op_valid = 1; alu_ct_op = 2'b10; funct = f; src_a = a; src_b = b;
      #1;
      chk({tag, " start_stall"}, stall, 0);
      hi0 = hi; lo0 = lo;
      tick();
      op_valid = 0;
      done_at = -1; busy_n = 0; busy_first = -1; busy_last = -1; early = 0;
      for (int k = 1; k <= 40 && done_at < 0; k++) begin
         #1;
         if (busy) begin
            busy_n++;
            if (busy_first < 0) busy_first = k;
            busy_last = k;
         end
         if (done) begin
            done_at = k;
            chk({tag, " hi"}, hi, eh);
            chk({tag, " lo"}, lo, el);
         end else if (hi !== hi0 || lo !== lo0) early = 1;
         tick();
      end
      chk({tag, " done_cycle"}, done_at, 34);
      chk({tag, " busy_cycles"}, {busy_first[15:0], busy_last[15:0], busy_n[15:0]}, {16'd1, 16'd33, 16'd33});
      chk({tag, " hilo_early"}, early, 0);
   endtask

   initial begin
      logic [31:0] eh, el, ra, rb;
      logic [5:0]  rf;
      int done_at, k2;
      bit stall_ok, seen;

      // reset with a live AND instruction on the inputs
      rst = 0; op_valid = 1; alu_ct_op = 2'b10; funct = 6'b100100; src_a = 0; src_b = 0;
      tick(); tick();
      #1;
      chk("rst alu_ct", alu_ct, 4'b0000);
      chk("rst stall", stall, 0);
      chk("rst hi_lo", {hi, lo}, 64'h0);
      chk("rst busy_done", {busy, done}, 2'b00);
      funct = 6'b100101;
      #1;
      chk("rst forces alu_ct", alu_ct, 4'b0000);
      rst = 1;
      #1;
      chk("rel alu_ct or", alu_ct, 4'b0001);
      funct = 6'b100100;
      #1;
      chk("rel alu_ct and", {alu_ct, hilo_sel}, {4'b0000, 2'b00});
      op_valid = 0;
      tick();

      // decode sweep
      add_row(2'b00, 6'b101010, 4'b0010, 2'b00, 1);
      add_row(2'b01, 6'b100100, 4'b0110, 2'b00, 1);
      add_row(2'b11, 6'b011000, 4'b0001, 2'b00, 1);
      add_row(2'b10, 6'b100000, 4'b0010, 2'b00, 1);
      add_row(2'b10, 6'b100001, 4'b0010, 2'b00, 1);
      add_row(2'b10, 6'b100010, 4'b0110, 2'b00, 1);
      add_row(2'b10, 6'b100011, 4'b0110, 2'b00, 1);
      add_row(2'b10, 6'b100100, 4'b0000, 2'b00, 1);
      add_row(2'b10, 6'b100101, 4'b0001, 2'b00, 1);
      add_row(2'b10, 6'b100111, 4'b1100, 2'b00, 1);
      add_row(2'b10, 6'b101010, 4'b0111, 2'b00, 1);
      add_row(2'b10, 6'b010000, 4'b0000, 2'b01, 1);
      add_row(2'b10, 6'b010010, 4'b0000, 2'b10, 1);
      add_row(2'b10, 6'b011000, 4'b0000, 2'b00, 0);
      add_row(2'b10, 6'b011001, 4'b0000, 2'b00, 0);
      add_row(2'b10, 6'b011010, 4'b0000, 2'b00, 0);
      add_row(2'b10, 6'b011011, 4'b0000, 2'b00, 0);
      add_row(2'b10, 6'b000000, 4'b0000, 2'b00, 1);
      add_row(2'b10, 6'b100110, 4'b0000, 2'b00, 1);
      foreach (rows[i]) begin
         op_valid = rows[i].valid; alu_ct_op = rows[i].op; funct = rows[i].f;
         #1;
         chk($sformatf("decode op%b f%b", rows[i].op, rows[i].f),
             {alu_ct, hilo_sel, stall}, {rows[i].code, rows[i].sel, 1'b0});
      end
      op_valid = 0;
      tick();

      // directed MDU cases
      run_mdu("multu 7*6", 6'b011001, 32'd7, 32'd6);
      run_mdu("mult -3*5", 6'b011000, 32'hFFFF_FFFD, 32'd5);
      run_mdu("div -7/2", 6'b011010, 32'hFFFF_FFF9, 32'd2);
      run_mdu("divu 9/0", 6'b011011, 32'd9, 32'd0);
      run_mdu("div min/-1", 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF);
      run_mdu("div -9/0", 6'b011010, 32'hFFFF_FFF7, 32'd0);
      run_mdu("multu max*max", 6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

      // mflo issued 3 cycles after a mult start
      model(6'b011000, 32'd1234, 32'hFFFF_FFC8, eh, el);
      op_valid = 1; alu_ct_op = 2'b10; funct = 6'b011000; src_a = 32'd1234; src_b = 32'hFFFF_FFC8;
      tick();
      op_valid = 0;
      tick(); tick();
      op_valid = 1; funct = 6'b010010;
      stall_ok = 1; done_at = -1;
      for (int k = 3; k <= 40 && done_at < 0; k++) begin
         #1;
         if (done) begin
            done_at = k;
            chk("mflo done stall", stall, 0);
            chk("mflo done sel", hilo_sel, 2'b10);
            chk("mflo done lo", lo, el);
         end else if (!stall) stall_ok = 0;
         tick();
      end
      op_valid = 0;
      chk("mflo stalled", stall_ok, 1);
      chk("mflo done_cycle", done_at, 34);

      // second MDU op presented while busy is held, then accepted in the done cycle
      op_valid = 1; alu_ct_op = 2'b10; funct = 6'b011001; src_a = 32'd3; src_b = 32'd4;
      tick();
      funct = 6'b011011; src_a = 32'd20; src_b = 32'd6;
      stall_ok = 1; done_at = -1;
      for (int k = 1; k <= 40 && done_at < 0; k++) begin
         #1;
         if (done) begin
            done_at = k;
            chk("held first lo", {hi, lo}, {32'd0, 32'd12});
            chk("held done stall", stall, 0);
         end else if (!stall) stall_ok = 0;
         tick();
      end
      op_valid = 0;
      chk("held stalled", stall_ok, 1);
      chk("held done_cycle", done_at, 34);
      seen = 0;
      for (int k = 1; k <= 40 && !seen; k++) begin
         #1;
         if (done) begin
            seen = 1;
            chk("held second", {hi, lo}, {32'd2, 32'd3});
         end
         tick();
      end
      chk("held second seen", seen, 1);

      // random MDU operations
      for (int n = 0; n < 12; n++) begin
         rf = {4'b0110, 2'($urandom_range(0, 3))};
         ra = $urandom;
         rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
         if ($urandom_range(0, 1) == 1) rb = rb >> $urandom_range(0, 28);
         run_mdu($sformatf("rand%0d f%b %h %h", n, rf, ra, rb), rf, ra, rb);
      end

      // reset in the middle of a divide
      op_valid = 1; alu_ct_op = 2'b10; funct = 6'b011010; src_a = 32'd100; src_b = 32'd7;
      tick();
      op_valid = 0;
      for (int k = 1; k < 10; k++) tick();
      rst = 0;
      #1;
      chk("midrst stall", stall, 0);
      tick();
      #1;
      chk("midrst state", {busy, done}, 2'b00);
      chk("midrst hi_lo", {hi, lo}, 64'h0);
      rst = 1;
      k2 = 0;
      for (int k = 0; k < 40; k++) begin
         #1;
         if (done || busy) k2++;
         tick();
      end
      chk("midrst no done", k2, 0);
      run_mdu("multu 2*3", 6'b011001, 32'd2, 32'd3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
